stopwatch_ctrl: RTL

Control block for the stopwatch. It debounces the raw run and clear buttons and sequences the time-counter datapath through a four-state machine. It also generates the one-second count tick from the system clock and drives the counter clear, the display-load enable and the run and hold status indicators. It sits between the buttons and the BCD time counter / seven-segment display register.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/stopwatch_debounce.sv | 50 +++++
 rtl/stopwatch_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and sizing helpers for the stopwatch control block.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    RUN   = 2'd1,
    SPLIT = 2'd2,
    STOP  = 2'd3
  } sw_state_e;

  // Bits needed to hold the values 0..max_val.
  function automatic int bits_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stopwatch_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and press pulse.
module stopwatch_debounce
  import stopwatch_pkg::*;
#(
  parameter int DBN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = bits_for(DBN);
  localparam logic [CW-1:0] C_MAX = CW'(DBN);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // The level flips on the sample after DBN differing ones, so a change needs DBN+1 samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_MAX) begin
        r_level <= r_sync2;
        r_press <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced buttons drive a four-state FSM and the one-second prescaler.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int SPN = 24_000_000,
  parameter int DBN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic b_run,
  input  logic b_clr,
  output logic tick,
  output logic cnt_clr,
  output logic dsp_ld,
  output logic s_run,
  output logic s_hld
);

  localparam int PW = bits_for(SPN - 1);
  localparam logic [PW-1:0] P_LAST = PW'(SPN - 1);

  sw_state_e     r_state;
  sw_state_e     w_state_next;
  logic          w_run_prs;
  logic          w_clr_prs;
  logic          w_unused_run_lvl;
  logic          w_unused_clr_lvl;
  logic          w_clr_issue;
  logic          w_run_next;
  logic          w_advance;
  logic          w_wrap;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_cnt_clr;

  stopwatch_debounce #(.DBN(DBN)) u_db_run (
    .clk   (clk),
    .rst   (rst),
    .raw   (b_run),
    .level (w_unused_run_lvl),
    .press (w_run_prs)
  );

  stopwatch_debounce #(.DBN(DBN)) u_db_clr (
    .clk   (clk),
    .rst   (rst),
    .raw   (b_clr),
    .level (w_unused_clr_lvl),
    .press (w_clr_prs)
  );

  // Run press takes priority; a clr press in the same cycle is dropped.
  always_comb begin
    w_state_next = r_state;
    w_clr_issue  = 1'b0;
    case (r_state)
      ZERO: begin
        if (w_run_prs)      w_state_next = RUN;
        else if (w_clr_prs) w_clr_issue  = 1'b1;
      end
      RUN: begin
        if (w_run_prs)      w_state_next = STOP;
        else if (w_clr_prs) w_state_next = SPLIT;
      end
      SPLIT: begin
        if (w_run_prs)      w_state_next = STOP;
        else if (w_clr_prs) w_state_next = RUN;
      end
      STOP: begin
        if (w_run_prs) begin
          w_state_next = RUN;
        end else if (w_clr_prs) begin
          w_state_next = ZERO;
          w_clr_issue  = 1'b1;
        end
      end
      default: w_state_next = ZERO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ZERO;
      r_cnt_clr <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt_clr <= w_clr_issue;
    end
  end

  assign s_run      = (r_state == RUN) || (r_state == SPLIT);
  assign s_hld      = (r_state == SPLIT);
  assign dsp_ld     = (r_state != SPLIT);
  assign w_run_next = (w_state_next == RUN) || (w_state_next == SPLIT);

  // Holding still on the stopping edge keeps a wrap from landing in STOP; the partial second survives.
  assign w_advance = s_run && w_run_next;
  assign w_wrap    = w_advance && (r_presc == P_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (w_clr_issue || w_wrap) r_presc <= '0;
      else if (w_advance)        r_presc <= r_presc + 1'b1;
    end
  end

  assign tick    = r_tick;
  assign cnt_clr = r_cnt_clr;

endmodule
